apb_mem_system: RTL
===================

// Module: apb_mem_system
// PURPOSE
//  Parametrised APB subsystem: a request queue feeds an APB master FSM, which drives an APB memory slave.
//  Accepts read/write commands with explicit address/data over a valid/ready port.
//  Returns read data with a one-cycle valid pulse.
//  Top-level memory subsystem for the test SoC; standalone under its bench.
// PARAMETERS
//  DATA_W     32   data width of PWDATA/PRDATA/rd_data_o
//  ADDR_W     8    command/PADDR width
//  MEM_DEPTH  256  memory words; power of two, <= 2**ADDR_W
//  CMD_DEPTH  4    request queue entries; power of two, >= 2
//  WAIT_CYC   1    slave wait states per transfer (0 = zero-wait)
// PORTS
//  clk          in   1       clock, all logic on posedge
//  reset        in   1       synchronous, active-low reset
//  req_valid_i  in   1       command valid
//  req_ready_o  out  1       queue can accept (= !full)
//  req_write_i  in   1       1 = write, 0 = read
//  req_addr_i   in   ADDR_W  word address
//  req_wdata_i  in   DATA_W  write data (ignored for reads)
//  rd_valid_o   out  1       one-cycle pulse: read completed
//  rd_data_o    out  DATA_W  read data, valid with rd_valid_o
//  rd_err_o     out  1       read completed with PSLVERR (see CONFIGURATION)
//  busy_o       out  1       queue non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - queue flushed; FSM -> IDLE; PSEL/PENABLE = 0.
//   - Outputs: req_ready_o=1, rd_valid_o=0, rd_data_o=0, rd_err_o=0, busy_o=0.
//   - Memory array is NOT reset.
//   - Reset mid-transfer aborts it; no rd_valid_o; a pending write may be lost.
//  Queue: push on req_valid_i & req_ready_o; no bypass.
//   - Push + pop in the same cycle are both legal.
//   - When full, req_ready_o=0 even if a pop occurs that cycle.
//  FSM: IDLE -> SETUP when queue non-empty.
//   - SETUP: PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA driven from the queue head; pop here.
//   - SETUP -> ACCESS unconditionally; ACCESS: PSEL=1, PENABLE=1; hold until PREADY.
//   - On PREADY: -> SETUP if queue non-empty (back-to-back), else -> IDLE.
//   - Address/control stay stable from SETUP through ACCESS.
//  Slave: PREADY asserts on the (WAIT_CYC+1)th ACCESS cycle (WAIT_CYC=0: first cycle).
//   - Write: mem[addr] <= PWDATA at the PREADY edge.
//   - Read: PRDATA = mem[addr] while PREADY=1.
//  Read completion: rd_valid_o=1 for exactly one cycle after the PREADY edge.
//   - rd_data_o registered and held until the next read completion.
//   - Writes never pulse rd_valid_o.
//  Latency: read accepted at edge T with an idle system -> SETUP after T+1, ACCESS after T+2.
//   - rd_valid_o high during cycle T+3+WAIT_CYC.
//  Throughput: one transfer per 2+WAIT_CYC cycles when the queue stays non-empty.
// CONFIGURATION
//  APB_SLVERR_EN defined:
//   - addr >= MEM_DEPTH -> slave returns PSLVERR=1 with PREADY.
//   - Write is dropped; read gives rd_data_o=0, rd_err_o=1 with rd_valid_o.
//  APB_SLVERR_EN undefined:
//   - addr indexes mem with its low $clog2(MEM_DEPTH) bits (wraps); no PSLVERR.
//   - rd_err_o tied 0.
// STRUCTURE
//  Package apb_sys_pkg:
//   - apb_state_e {IDLE, SETUP, ACCESS}
//   - cmd_t struct {write, addr, wdata}, parametrised via localparams
//   - default widths
//  Sub-module apb_mem_slave (memory, wait-state counter, PSLVERR).
//  Queue and master FSM live in apb_mem_system.
// TESTING
//  1. reset=0 for 2 cycles mid-burst -> busy_o=0, req_ready_o=1, rd_valid_o=0 next cycle; queue empty.
//  2. WAIT_CYC=0: write 0xDEADBEEF@0x10, then read 0x10 -> rd_valid_o one cycle, rd_data_o=0xDEADBEEF,
//     at T+3 after the read accept.
//  3. Push 5 commands back-to-back, CMD_DEPTH=4, no drain stall -> req_ready_o low only when full;
//     no command lost or duplicated; order preserved.
//  4. WAIT_CYC=3: read -> PENABLE held 4 cycles; PADDR stable throughout; rd_valid_o at T+6.
//  5. MEM_DEPTH=128, read 0x85 after writing 0x05=0x1234:
//     - APB_SLVERR_EN: rd_err_o=1, rd_data_o=0.
//     - else: rd_data_o=0x1234, rd_err_o=0.
//  6. 512 cycles random valid/write/addr vs scoreboard model -> all read data match, one pulse per read.

Source files
------------

// File: rtl/apb_sys_pkg.sv
// Shared types and default widths for the APB memory subsystem.
package apb_sys_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned MEM_DEPTH_DEF = 256;
  localparam int unsigned CMD_DEPTH_DEF = 4;
  localparam int unsigned WAIT_CYC_DEF  = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // Command payload at the default widths
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/apb_mem_slave.sv
// APB memory slave: word array, programmable wait states, optional PSLVERR.
// Optional feature: APB_SLVERR_EN flags addresses >= MEM_DEPTH as errors;
// without it the address wraps onto the low index bits.
module apb_mem_slave
  import apb_sys_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned WAIT_CYC  = WAIT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready_c,
  output logic [DATA_W-1:0] prdata_c,
  output logic              pslverr_c
);

  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned WCNT_W = $clog2(WAIT_CYC + 2);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [WCNT_W-1:0] wait_cnt;
  logic [IDX_W-1:0]  idx_c;
  logic              access_c;
  logic              err_c;

`ifndef APB_SLVERR_EN
  logic unused_addr;
  assign unused_addr = ^paddr;
`endif

  // Transfer decode: ready after WAIT_CYC stalled ACCESS cycles, read mux
  always_comb begin
    access_c = psel & penable;
    idx_c    = paddr[IDX_W-1:0];
`ifdef APB_SLVERR_EN
    err_c    = ({1'b0, paddr} >= (ADDR_W + 1)'(MEM_DEPTH));
`else
    err_c    = 1'b0;
`endif
    pready_c  = access_c & (wait_cnt == WCNT_W'(WAIT_CYC));
    pslverr_c = pready_c & err_c;
    prdata_c  = '0;
    if (pready_c && !err_c) begin
      prdata_c = mem[idx_c];
    end
  end

  // Wait-state counter: counts ACCESS cycles not yet completed
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (access_c && !pready_c) begin
      wait_cnt <= wait_cnt + WCNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Memory array, deliberately not reset; writes commit on the PREADY edge
  always_ff @(posedge clk) begin
    if (reset && pready_c && pwrite && !err_c) begin
      mem[idx_c] <= pwdata;
    end
  end

endmodule

// File: rtl/apb_mem_system.sv
// APB subsystem top: command queue -> APB master FSM -> apb_mem_slave.
// Optional feature: APB_SLVERR_EN enables out-of-range error reporting on rd_err_o.
module apb_mem_system
  import apb_sys_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned CMD_DEPTH = CMD_DEPTH_DEF,
  parameter int unsigned WAIT_CYC  = WAIT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_err_o,
  output logic              busy_o
);

  localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W = $clog2(CMD_DEPTH + 1);

  logic              q_write [CMD_DEPTH];
  logic [ADDR_W-1:0] q_addr  [CMD_DEPTH];
  logic [DATA_W-1:0] q_wdata [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              push_c;
  logic              pop_c;

  apb_state_e        state;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready_c;
  logic              pslverr_c;
  logic [DATA_W-1:0] prdata_c;

  // Queue handshake: head is consumed during the SETUP cycle
  always_comb begin
    push_c    = req_valid_i & req_ready_o;
    pop_c     = (state == SETUP);
    count_nxt = count;
    case ({push_c, pop_c})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Queue storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_c) begin
      q_write[wr_ptr] <= req_write_i;
      q_addr[wr_ptr]  <= req_addr_i;
      q_wdata[wr_ptr] <= req_wdata_i;
    end
  end

  // Queue pointers, occupancy and registered ready (low whenever full)
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      req_ready_o <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_nxt;
      req_ready_o <= (count_nxt != CNT_W'(CMD_DEPTH));
    end
  end

  // APB master FSM; address/control are loaded on entry to SETUP and held
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= q_write[rd_ptr];
            paddr   <= q_addr[rd_ptr];
            pwdata  <= q_wdata[rd_ptr];
            busy_o  <= 1'b1;
          end else begin
            busy_o  <= (count_nxt != '0);
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
          busy_o  <= 1'b1;
        end
        ACCESS: begin
          if (pready_c) begin
            if (count != '0) begin
              state   <= SETUP;
              penable <= 1'b0;
              pwrite  <= q_write[rd_ptr];
              paddr   <= q_addr[rd_ptr];
              pwdata  <= q_wdata[rd_ptr];
              busy_o  <= 1'b1;
            end else begin
              state   <= IDLE;
              psel    <= 1'b0;
              penable <= 1'b0;
              busy_o  <= (count_nxt != '0);
            end
          end else begin
            busy_o <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // Read completion: one-cycle pulse, data held until the next read
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
`ifdef APB_SLVERR_EN
      rd_err_o   <= 1'b0;
`endif
    end else begin
      rd_valid_o <= 1'b0;
      if (pready_c && !pwrite) begin
        rd_valid_o <= 1'b1;
        rd_data_o  <= prdata_c;
`ifdef APB_SLVERR_EN
        rd_err_o   <= pslverr_c;
`endif
      end
    end
  end

`ifndef APB_SLVERR_EN
  logic unused_slverr;
  assign unused_slverr = pslverr_c;
  assign rd_err_o      = 1'b0;
`endif

  apb_mem_slave #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .WAIT_CYC  (WAIT_CYC)
  ) u_slave (
    .clk       (clk),
    .reset     (reset),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pready_c  (pready_c),
    .prdata_c  (prdata_c),
    .pslverr_c (pslverr_c)
  );

endmodule
